// File: rtl/pio_irq_service_master_pkg.sv
// Shared types for the button-PIO service initiator: FSM encoding, PIO word offsets,
// and the single-request descriptor handed to the bus transfer engine.
package pio_irq_service_master_pkg;

    typedef enum logic [3:0] {
        S_DISARMED,
        S_ARM,
        S_IDLE,
        S_DISARM,
        S_RD_CAP,
        S_RD_WAIT,
        S_CLR_CAP,
        S_EVENT,
        S_HOLD
    } state_t;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_MASK = 2'd2;
    localparam logic [1:0] REG_CAP  = 2'd3;

    typedef struct packed {
        logic        read;
        logic        write;
        logic [1:0]  addr;
        logic [31:0] wdata;
    } avm_req_t;

    localparam avm_req_t REQ_NONE = '0;

    function automatic avm_req_t mk_req(input logic rd, input logic wr,
                                        input logic [1:0] a, input logic [31:0] d);
        avm_req_t r;
        r.read  = rd;
        r.write = wr;
        r.addr  = a;
        r.wdata = d;
        return r;
    endfunction

endpackage

// File: rtl/pio_irq_service_master_if.sv
// Avalon-MM link between the service initiator and the button PIO slave.
interface pio_irq_service_master_if;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (output address, read, write, writedata,
                    input  readdata, waitrequest);
    modport slave  (input  address, read, write, writedata,
                    output readdata, waitrequest);
endinterface

// File: rtl/pio_irq_service_master_xfer.sv
// Single-transfer engine: presents the FSM's request on the bus and flags the cycle
// on which fixed-latency read data is valid.
module pio_irq_service_master_xfer
    import pio_irq_service_master_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int DATA_W       = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  avm_req_t                  req,
    output logic                      accept,
    output logic                      rdata_valid,
    output logic [DATA_W-1:0]         rdata,
    pio_irq_service_master_if.master  avm
);

    logic                    rd_acc;
    logic [READ_LATENCY:1]   vld_pipe;

    // The FSM holds req constant in a request state, so the bus stays stable under stall.
    assign avm.address   = req.addr;
    assign avm.read      = req.read;
    assign avm.write     = req.write;
    assign avm.writedata = req.wdata;

    assign accept = (req.read | req.write) & ~avm.waitrequest;
    assign rd_acc = req.read & ~avm.waitrequest;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= rd_acc;
            for (int i = 2; i <= READ_LATENCY; i++)
                vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign rdata_valid = vld_pipe[READ_LATENCY];
    assign rdata       = avm.readdata[DATA_W-1:0];

endmodule

// File: rtl/pio_irq_service_master.sv
// Services an edge-capture button PIO without the CPU: arm mask, read/clear capture on irq,
// emit one event strobe per non-zero capture, then ignore irq for a debounce holdoff.
module pio_irq_service_master
    import pio_irq_service_master_pkg::*;
#(
    parameter int          DATA_W       = 1,
    parameter logic [31:0] MASK_VALUE   = 32'd1,
    parameter int          READ_LATENCY = 1,
    parameter int          HOLDOFF      = 50000,
    parameter int          CNT_W        = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      irq,
    pio_irq_service_master_if.master  avm,
    output logic                      event_pulse,
    output logic [DATA_W-1:0]         event_data,
    output logic [CNT_W-1:0]          event_count,
    output logic                      busy
);

    localparam int HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

    state_t            state_q, state_d;
    avm_req_t          req;
    logic              accept, rdata_valid;
    logic [DATA_W-1:0] rdata, cap_q;
    logic [HW-1:0]     hold_q;

    pio_irq_service_master_xfer #(
        .READ_LATENCY (READ_LATENCY),
        .DATA_W       (DATA_W)
    ) u_xfer (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .accept      (accept),
        .rdata_valid (rdata_valid),
        .rdata       (rdata),
        .avm         (avm)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_DISARMED;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_DISARMED: if (enable) state_d = S_ARM;
            S_ARM:      if (accept) state_d = S_IDLE;
            S_IDLE: begin
                if (!enable)  state_d = S_DISARM;
                else if (irq) state_d = S_RD_CAP;
            end
            S_DISARM:   if (accept) state_d = S_DISARMED;
            S_RD_CAP:   if (accept) state_d = S_RD_WAIT;
            S_RD_WAIT:  if (rdata_valid) state_d = S_CLR_CAP;
            // A zero capture is a spurious irq: clear it but stay silent.
            S_CLR_CAP:  if (accept) state_d = (cap_q != '0) ? S_EVENT : S_IDLE;
            S_EVENT:    state_d = (HOLDOFF == 0) ? S_IDLE : S_HOLD;
            S_HOLD:     if (hold_q <= HW'(1)) state_d = S_IDLE;
            default:    state_d = S_DISARMED;
        endcase
    end

    always_comb begin
        req         = REQ_NONE;
        event_pulse = 1'b0;
        busy        = !(state_q inside {S_IDLE, S_DISARMED});
        case (state_q)
            S_ARM:     req = mk_req(1'b0, 1'b1, REG_MASK, MASK_VALUE);
            S_DISARM:  req = mk_req(1'b0, 1'b1, REG_MASK, 32'd0);
            S_RD_CAP:  req = mk_req(1'b1, 1'b0, REG_CAP,  32'd0);
            S_CLR_CAP: req = mk_req(1'b0, 1'b1, REG_CAP,  32'd0);
            S_EVENT:   event_pulse = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_q       <= '0;
            hold_q      <= '0;
            event_data  <= '0;
            event_count <= '0;
        end else begin
            if (state_q == S_RD_WAIT && rdata_valid)
                cap_q <= rdata;
            if (state_q == S_EVENT) begin
                event_data <= cap_q;
                if (event_count != '1)
                    event_count <= event_count + 1'b1;
                hold_q <= HW'(HOLDOFF);
            end else if (state_q == S_HOLD) begin
                hold_q <= hold_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pio_irq_service_master.sv
// Directed bench: button PIO slave model with programmable stall and 1-cycle read latency.
module tb_pio_irq_service_master;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       irq = 1'b0;
    logic       event_pulse, busy;
    logic [3:0] event_data;
    logic [1:0] event_count;

    int checks = 0, failures = 0;
    int stall_cfg = 0, req_age = 0;
    logic [3:0] cap_val = 4'h0;
    int n_rd = 0, n_wr = 0, n_req = 0, n_evt = 0, n_viol = 0;
    logic [1:0]  last_wr_addr = 2'd0;
    logic [31:0] last_wr_data = 32'd0;
    logic        prev_stalled = 1'b0;
    logic [35:0] prev_req = '0;
    int r0, w0, e0, q0;

    pio_irq_service_master_if bus();

    pio_irq_service_master #(
        .DATA_W(4), .MASK_VALUE(32'd1), .READ_LATENCY(1), .HOLDOFF(8), .CNT_W(2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .irq         (irq),
        .avm         (bus.master),
        .event_pulse (event_pulse),
        .event_data  (event_data),
        .event_count (event_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    assign bus.waitrequest = (bus.read | bus.write) && (req_age < stall_cfg);

    // Slave model and bus monitor; read data is valid only the cycle after an accepted read.
    always @(posedge clk) begin
        if (bus.read | bus.write) begin
            n_req   <= n_req + 1;
            req_age <= bus.waitrequest ? req_age + 1 : 0;
        end else begin
            req_age <= 0;
        end
        if (prev_stalled && ({bus.read, bus.write, bus.address, bus.writedata} != prev_req))
            n_viol <= n_viol + 1;
        prev_stalled <= (bus.read | bus.write) && bus.waitrequest;
        prev_req     <= {bus.read, bus.write, bus.address, bus.writedata};
        if (bus.read && !bus.waitrequest) begin
            n_rd        <= n_rd + 1;
            bus.readdata <= {28'h0, cap_val};
        end else begin
            bus.readdata <= 32'hFFFF_FFFA;
        end
        if (bus.write && !bus.waitrequest) begin
            n_wr         <= n_wr + 1;
            last_wr_addr <= bus.address;
            last_wr_data <= bus.writedata;
        end
        if (event_pulse) n_evt <= n_evt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_evt(input string tag, input int budget);
        int k = 0;
        while (!event_pulse && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(event_pulse), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step(3);
        chk("rst_read",  32'(bus.read), 0);
        chk("rst_write", 32'(bus.write), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_pulse", 32'(event_pulse), 0);
        chk("rst_count", 32'(event_count), 0);
        chk("rst_data",  32'(event_data), 0);

        // Arm: write mask=1 to address 2, then idle
        reset_n = 1'b1;
        enable  = 1'b1;
        step(1);
        chk("arm_write", 32'(bus.write), 1);
        chk("arm_addr",  32'(bus.address), 2);
        chk("arm_data",  bus.writedata, 1);
        step(1);
        chk("arm_busy",  32'(busy), 0);
        chk("arm_nwr",   32'(n_wr), 1);
        chk("arm_nrd",   32'(n_rd), 0);

        // Service, no stall: event 4 cycles after irq seen in IDLE
        cap_val = 4'h5;
        irq = 1'b1;
        step(1);
        irq = 1'b0;
        chk("svc_read",  32'(bus.read), 1);
        chk("svc_raddr", 32'(bus.address), 3);
        step(2);
        chk("svc_clr_wr",   32'(bus.write), 1);
        chk("svc_clr_addr", 32'(bus.address), 3);
        chk("svc_clr_data", bus.writedata, 0);
        chk("svc_nopulse",  32'(event_pulse), 0);
        step(1);
        chk("svc_pulse", 32'(event_pulse), 1);
        step(1);
        chk("svc_pulse_1cyc", 32'(event_pulse), 0);
        chk("svc_count", 32'(event_count), 1);
        chk("svc_data",  32'(event_data), 5);
        chk("svc_hold_busy", 32'(busy), 1);
        step(7);
        chk("hold_last_busy", 32'(busy), 1);
        step(1);
        chk("hold_exit_busy", 32'(busy), 0);

        // Stall 3 cycles on every transfer
        stall_cfg = 3;
        r0 = n_rd; w0 = n_wr; e0 = n_evt;
        cap_val = 4'h3;
        irq = 1'b1;
        step(1);
        irq = 1'b0;
        chk("stall_read", 32'(bus.read), 1);
        wait_evt("stall_evt_timeout", 40);
        step(1);
        chk("stall_data",  32'(event_data), 3);
        chk("stall_count", 32'(event_count), 2);
        chk("stall_nrd",   32'(n_rd - r0), 1);
        chk("stall_nwr",   32'(n_wr - w0), 1);
        chk("stall_viol",  32'(n_viol), 0);
        chk("stall_clr",   {28'h0, last_wr_addr, 2'b0} | last_wr_data, 32'hC);
        step(12);
        chk("stall_one_evt", 32'(n_evt - e0), 1);
        stall_cfg = 0;

        // Spurious irq: capture reads 0 -> clear but no event
        cap_val = 4'h0;
        w0 = n_wr; e0 = n_evt;
        irq = 1'b1;
        step(1);
        irq = 1'b0;
        step(2);
        chk("spur_clr_wr",   32'(bus.write), 1);
        chk("spur_clr_addr", 32'(bus.address), 3);
        step(1);
        chk("spur_idle",    32'(busy), 0);
        chk("spur_nopulse", 32'(event_pulse), 0);
        step(2);
        chk("spur_nevt",  32'(n_evt - e0), 0);
        chk("spur_nwr",   32'(n_wr - w0), 1);
        chk("spur_count", 32'(event_count), 2);
        chk("spur_data",  32'(event_data), 3);

        // irq held through holdoff; third event saturates the 2-bit count, fourth stays
        cap_val = 4'h6;
        irq = 1'b1;
        wait_evt("hold_evt1_timeout", 20);
        step(1);
        chk("sat_count3", 32'(event_count), 3);
        chk("sat_data",   32'(event_data), 6);
        q0 = n_req;
        step(7);
        chk("hold_no_bus", 32'(n_req - q0), 0);
        chk("hold_busy",   32'(busy), 1);
        step(1);
        chk("hold_idle_read", 32'(bus.read), 0);
        chk("hold_idle_busy", 32'(busy), 0);
        step(1);
        chk("hold_resvc_read", 32'(bus.read), 1);
        step(3);
        chk("hold_evt2", 32'(event_pulse), 1);
        irq = 1'b0;
        step(1);
        chk("sat_count_stay", 32'(event_count), 3);
        step(10);

        // Disable in IDLE: write mask=0, then no service
        enable = 1'b0;
        step(1);
        chk("dis_write", 32'(bus.write), 1);
        chk("dis_addr",  32'(bus.address), 2);
        chk("dis_data",  bus.writedata, 0);
        step(1);
        chk("dis_busy", 32'(busy), 0);
        r0 = n_rd;
        irq = 1'b1;
        step(3);
        chk("dis_noread", 32'(n_rd - r0), 0);
        irq = 1'b0;

        // Reset mid-transfer (arm write stalled), then re-arm
        stall_cfg = 3;
        enable = 1'b1;
        step(1);
        chk("mid_write", 32'(bus.write), 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_write", 32'(bus.write), 0);
        chk("mid_rst_busy",  32'(busy), 0);
        chk("mid_rst_count", 32'(event_count), 0);
        step(2);
        stall_cfg = 0;
        w0 = n_wr;
        reset_n = 1'b1;
        step(3);
        chk("rearm_nwr",  32'(n_wr - w0), 1);
        chk("rearm_addr", 32'(last_wr_addr), 2);
        chk("rearm_data", last_wr_data, 1);
        chk("rearm_busy", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
